// File: rtl/mul_result_collector_if.sv
// Stream bundle for the product collector: a beat input stream and a result output stream.
// The slave modport is the collector; the master modport is the producer/consumer side.
interface mul_result_collector_if #(
    parameter int Nbits = 4,
    parameter int Ndata = 8,
    parameter int Nmul  = 2
);
    localparam int PW = 2 * Nbits;
    localparam int BW = (Ndata / Nmul) * PW;
    localparam int SW = PW + $clog2(Ndata);

    logic                  in_valid;
    logic                  in_ready;
    logic [BW-1:0]         in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [Ndata*PW-1:0]   out_vec;
    logic [SW-1:0]         out_sum;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_vec, out_sum
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_vec, out_sum
    );
endinterface

// File: rtl/mul_result_collector.sv
// Collects Nmul beats of unsigned products into one vector and accumulates their sum,
// then holds the assembled result until the consumer takes it.
module mul_result_collector #(
    parameter int Nbits = 4,
    parameter int Ndata = 8,
    parameter int Nmul  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    mul_result_collector_if.slave    bus
);
    localparam int PW = 2 * Nbits;
    localparam int NE = Ndata / Nmul;
    localparam int BW = NE * PW;
    localparam int SW = PW + $clog2(Ndata);
    localparam int CW = (Nmul > 1) ? $clog2(Nmul) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(Nmul - 1);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t              state_reg;
    logic [CW-1:0]       cnt_reg;
    logic [SW-1:0]       acc_reg;
    logic [Ndata*PW-1:0] vec_reg;

    // Adder chain over the products of the incoming beat, widened to the sum width.
    logic [SW-1:0] part_sum [NE+1];
    assign part_sum[0] = '0;

    generate
        for (genvar gi = 0; gi < NE; gi++) begin : g_beat_sum
            assign part_sum[gi+1] = part_sum[gi] + SW'(bus.in_data[gi*PW +: PW]);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= COLLECT;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            vec_reg   <= '0;
        end else if (clear) begin
            state_reg <= COLLECT;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            vec_reg   <= '0;
        end else begin
            case (state_reg)
                COLLECT: begin
                    if (bus.in_valid) begin
                        vec_reg[int'(cnt_reg)*BW +: BW] <= bus.in_data;
                        acc_reg <= acc_reg + part_sum[NE];
                        if (cnt_reg == LAST_BEAT) begin
                            state_reg <= HOLD;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    // out_vec is deliberately kept; only the counter and sum restart.
                    if (bus.out_ready) begin
                        state_reg <= COLLECT;
                        cnt_reg   <= '0;
                        acc_reg   <= '0;
                    end
                end
                default: state_reg <= COLLECT;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == COLLECT);
    assign bus.out_valid = (state_reg == HOLD);
    assign bus.out_vec   = vec_reg;
    assign bus.out_sum   = acc_reg;
endmodule

// File: tb/tb_mul_result_collector.sv
// Directed bench for mul_result_collector: stimulus pushes expected results into queues,
// negedge monitors pop and compare on every output handshake.
module tb_mul_result_collector;
    logic clk;
    logic reset;
    logic clear;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [63:0] vec;
        logic [10:0] sum;
    } exp_t;

    exp_t q2[$];
    exp_t q1[$];

    mul_result_collector_if #(.Nbits(4), .Ndata(8), .Nmul(2)) bus2 ();
    mul_result_collector_if #(.Nbits(4), .Ndata(8), .Nmul(1)) bus1 ();

    mul_result_collector #(.Nbits(4), .Ndata(8), .Nmul(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus2.slave)
    );

    mul_result_collector #(.Nbits(4), .Ndata(8), .Nmul(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] B0   = 32'h0C0A0600;
    localparam logic [31:0] B1   = 32'h00060A0C;
    localparam logic [63:0] NOMV = 64'h00060A0C0C0A0600;
    localparam logic [31:0] MAXB = 32'hE1E1E1E1;
    localparam logic [31:0] ONEB = 32'h01010101;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push2(input logic [63:0] v, input logic [10:0] s);
        exp_t e;
        e.vec = v;
        e.sum = s;
        q2.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d);
        bus2.in_valid = 1'b1;
        bus2.in_data  = d;
        tick();
        bus2.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin : mon2
        exp_t e;
        if (reset && bus2.out_valid && bus2.out_ready) begin
            if (q2.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_result2: got vec %0h sum %0d, expected none", bus2.out_vec, bus2.out_sum);
            end else begin
                e = q2.pop_front();
                $display("result2 vec=%016h sum=%0d (expected %016h / %0d)", bus2.out_vec, bus2.out_sum, e.vec, e.sum);
                chk("result2_vec", bus2.out_vec, e.vec);
                chk("result2_sum", 64'(bus2.out_sum), 64'(e.sum));
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (reset && bus1.out_valid && bus1.out_ready) begin
            if (q1.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_result1: got vec %0h sum %0d, expected none", bus1.out_vec, bus1.out_sum);
            end else begin
                e = q1.pop_front();
                $display("result1 vec=%016h sum=%0d (expected %016h / %0d)", bus1.out_vec, bus1.out_sum, e.vec, e.sum);
                chk("result1_vec", bus1.out_vec, e.vec);
                chk("result1_sum", 64'(bus1.out_sum), 64'(e.sum));
            end
        end
    end

    initial begin
        exp_t e1;
        reset          = 1'b0;
        clear          = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_data   = '0;
        bus2.out_ready = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_data   = '0;
        bus1.out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_in_ready", 64'(bus2.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus2.out_valid), 64'd0);
        chk("rst_out_vec", bus2.out_vec, 64'd0);
        chk("rst_out_sum", 64'(bus2.out_sum), 64'd0);
        reset = 1'b1;
        tick();

        // Nominal vector, consumer always ready
        bus2.out_ready = 1'b1;
        push2(NOMV, 11'd56);
        beat(B0);
        chk("nom_mid_valid", 64'(bus2.out_valid), 64'd0);
        beat(B1);
        chk("nom_valid", 64'(bus2.out_valid), 64'd1);
        chk("nom_in_ready_hold", 64'(bus2.in_ready), 64'd0);
        tick();
        chk("nom_valid_one_cycle", 64'(bus2.out_valid), 64'd0);
        chk("nom_in_ready_after", 64'(bus2.in_ready), 64'd1);

        // Gap between beats, then back-pressure with a beat offered during HOLD
        bus2.out_ready = 1'b0;
        push2(NOMV, 11'd56);
        beat(B0);
        repeat (3) tick();
        chk("gap_no_valid", 64'(bus2.out_valid), 64'd0);
        beat(B1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(bus2.out_valid), 64'd1);
            chk("bp_in_ready", 64'(bus2.in_ready), 64'd0);
            chk("bp_vec", bus2.out_vec, NOMV);
            chk("bp_sum", 64'(bus2.out_sum), 64'd56);
            bus2.in_valid = (i == 2);
            bus2.in_data  = 32'hFFFFFFFF;
            tick();
        end
        bus2.in_valid  = 1'b0;
        bus2.out_ready = 1'b1;
        chk("bp_vec_after_offer", bus2.out_vec, NOMV);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("bp_single_result", 64'(bus2.out_valid), 64'd0);
            tick();
        end

        // Maximum products, sum must not wrap
        push2({MAXB, MAXB}, 11'd1800);
        beat(MAXB);
        beat(MAXB);
        chk("max_sum", 64'(bus2.out_sum), 64'd1800);
        tick();

        // Clear after the first beat; beat offered with clear is dropped
        push2({ONEB, ONEB}, 11'd8);
        beat(B0);
        clear         = 1'b1;
        bus2.in_valid = 1'b1;
        bus2.in_data  = B1;
        tick();
        clear         = 1'b0;
        bus2.in_valid = 1'b0;
        chk("clr_vec", bus2.out_vec, 64'd0);
        chk("clr_sum", 64'(bus2.out_sum), 64'd0);
        chk("clr_in_ready", 64'(bus2.in_ready), 64'd1);
        beat(ONEB);
        chk("clr_one_beat_no_valid", 64'(bus2.out_valid), 64'd0);
        beat(ONEB);
        chk("clr_sum_final", 64'(bus2.out_sum), 64'd8);
        tick();

        // Asynchronous reset while holding a result
        bus2.out_ready = 1'b0;
        beat(B0);
        beat(B1);
        chk("rst_hold_valid", 64'(bus2.out_valid), 64'd1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid_drop", 64'(bus2.out_valid), 64'd0);
        chk("arst_in_ready", 64'(bus2.in_ready), 64'd1);
        chk("arst_vec", bus2.out_vec, 64'd0);
        chk("arst_sum", 64'(bus2.out_sum), 64'd0);
        @(negedge clk);
        reset          = 1'b1;
        bus2.out_ready = 1'b1;
        push2(NOMV, 11'd56);
        bus2.in_valid  = 1'b1;
        bus2.in_data   = B0;
        tick();
        bus2.in_valid  = 1'b0;
        beat(B1);
        chk("arst_fresh_valid", 64'(bus2.out_valid), 64'd1);
        tick();

        // Single-beat configuration
        bus1.out_ready = 1'b1;
        e1.vec = 64'h0706050403020100;
        e1.sum = 11'd28;
        q1.push_back(e1);
        bus1.in_valid = 1'b1;
        bus1.in_data  = 64'h0706050403020100;
        tick();
        bus1.in_valid = 1'b0;
        chk("n1_valid", 64'(bus1.out_valid), 64'd1);
        chk("n1_in_ready", 64'(bus1.in_ready), 64'd0);
        chk("n1_sum", 64'(bus1.out_sum), 64'd28);
        tick();
        chk("n1_valid_after", 64'(bus1.out_valid), 64'd0);

        // Every pushed expectation must have been consumed within a bounded wait
        for (int i = 0; i < 20 && (q2.size() + q1.size()) != 0; i++) tick();
        chk("pending_results", 64'(q2.size() + q1.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/mul_result_collector.md
MUL_RESULT_COLLECTOR -- requirements
Module: mul_result_collector

Interface
REQ-001 The block SHALL have parameter Nbits, default 4: width of one operand element.
REQ-002 The block SHALL have parameter Ndata, default 8: elements per full vector.
REQ-003 The block SHALL have parameter Nmul, default 2: beats per vector, with Ndata divisible by Nmul.
REQ-004 Derived widths SHALL be PW = 2*Nbits (product), BW = (Ndata/Nmul)*PW (beat), SW = PW + clog2(Ndata) (sum).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port clear, input, 1 bit: synchronous abort of the vector in progress.
REQ-008 The block SHALL have port in_valid, input, 1 bit: a product beat is present.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-010 The block SHALL have port in_data, input, BW bits: Ndata/Nmul unsigned PW-bit products, element 0 at the LSBs.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the assembled result is held.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-013 The block SHALL have port out_vec, output, Ndata*PW bits: the full product vector.
REQ-014 The block SHALL have port out_sum, output, SW bits: the sum of all Ndata products (scalar product).

Function
REQ-015 The block SHALL implement a two-state FSM with states COLLECT and HOLD.
REQ-016 In COLLECT, in_ready SHALL be 1 and out_valid SHALL be 0; in HOLD, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-017 A beat SHALL be accepted on a rising edge with in_valid=1, in_ready=1 and clear=0.
REQ-018 The beat counter SHALL run 0..Nmul-1; accepted beat k SHALL be written to out_vec bits [(k+1)*BW-1 : k*BW].
REQ-019 Each accepted beat SHALL add the unsigned sum of its Ndata/Nmul products to the sum accumulator, zero-extended to SW bits with no overflow possible.
REQ-020 Accepting beat Nmul-1 SHALL transition the FSM to HOLD on the same edge, with out_vec and out_sum final and out_valid=1 in the next cycle (latency 1 cycle from the last beat).
REQ-021 In HOLD, out_vec and out_sum SHALL remain stable until handshake completion, regardless of in_valid.
REQ-022 A HOLD cycle with out_ready=1 SHALL complete the handshake; on that edge the FSM SHALL go to COLLECT with the beat counter and accumulator cleared.
REQ-023 out_vec SHALL retain its old value until overwritten by new beats.
REQ-024 No beat SHALL be accepted in the handshake cycle, because in_ready=0 in HOLD; the earliest next acceptance SHALL be the following cycle.
REQ-025 clear=1 SHALL take priority over every other input: the FSM goes to COLLECT, the counter and accumulator go to 0, and out_vec goes to 0, with no beat accepted in that cycle.
REQ-026 clear=1 in HOLD SHALL discard the held result without a handshake.
REQ-027 When Nmul=1, every accepted beat SHALL go directly to HOLD.
REQ-028 in_valid=0 in COLLECT SHALL leave all state unchanged; gaps between beats SHALL be allowed and unbounded.

Reset
REQ-029 reset=0 SHALL asynchronously force COLLECT, counter=0, accumulator=0 and out_vec=0, giving out_valid=0 and in_ready=1 while reset is low.
REQ-030 Reset mid-vector or in HOLD SHALL discard all partial and held data.
REQ-031 Reset release SHALL be synchronous to clk; the first beat SHALL be acceptable on the first edge after release.

Verification
REQ-032 Nominal vector: defaults; beat0 = {12,10,6,0} (MSB to LSB, 8-bit each), beat1 = {0,6,10,12} on consecutive cycles, out_ready=1 -> out_valid=1 for exactly 1 cycle, out_vec = {0,6,10,12,12,10,6,0}, out_sum = 56.
REQ-033 Back-pressure and gaps: same beats with a 3-cycle in_valid gap, then out_ready=0 for 5 cycles -> out_valid held 5+ cycles with stable data, in_ready=0 throughout HOLD, a beat offered in HOLD is not accepted, and a single result is produced.
REQ-034 Max values: all products 225 on both beats -> out_sum = 1800, no wrap.
REQ-035 clear: clear asserted after beat0, then beat1, beat0', beat1' with all products 1 -> out_sum = 8 and only the post-clear beats are reflected.
REQ-036 Reset: reset=0 asserted asynchronously in HOLD between edges -> out_valid drops immediately, out_vec = 0, and the next two beats produce a correct fresh result.
REQ-037 Nmul=1: a single beat of {7,6,5,4,3,2,1,0} products -> out_valid the next cycle, out_sum = 28.
